// File: rtl/rs_gbx_pkg.sv
// Shared types and helpers for the GBX AFE FIFO read-side gearbox.
// Provides the read FSM state enum, the width ratio helper and an elaboration check.
`ifndef RS_GBX_PKG_SV
`define RS_GBX_PKG_SV

// Expands to a generate-if that stops elaboration when cond is false.
`define GBX_ELAB_CHECK(lbl, cond, msg) \
    if (!(cond)) begin : lbl \
        $error(msg); \
    end

package rs_gbx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } gbx_rd_state_t;

    function automatic int gbx_ratio(input int datasize, input int out_width);
        return datasize / out_width;
    endfunction

endpackage

`endif

// File: rtl/rs_fifo_rd_gearbox.sv
// FIFO read-side drain: pops full words and emits them as narrow valid/ready slices.
// Ports: rclk/rd_reset_n, fifo_empty/fifo_rd_data/fifo_rd, flush, out_data/out_valid/out_last/out_ready.
module rs_fifo_rd_gearbox
    import rs_gbx_pkg::*;
#(
    parameter int DATASIZE  = 32,
    parameter int OUT_WIDTH = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                 rclk,
    input  logic                 rd_reset_n,
    input  logic                 fifo_empty,
    input  logic [DATASIZE-1:0]  fifo_rd_data,
    output logic                 fifo_rd,
    input  logic                 flush,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready
);

    localparam int RATIO = gbx_ratio(DATASIZE, OUT_WIDTH);
    localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);

    `GBX_ELAB_CHECK(g_bad_div, (DATASIZE % OUT_WIDTH) == 0,
                    "DATASIZE must be a multiple of OUT_WIDTH")
    `GBX_ELAB_CHECK(g_bad_ratio, RATIO >= 2,
                    "DATASIZE/OUT_WIDTH must be at least 2")

    gbx_rd_state_t       state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DATASIZE-1:0] word_q, word_d;
    logic                run_q;

    logic          acc;
    logic          last;
    logic          pop;
    logic [CW-1:0] sel;

    // State register
    always_ff @(posedge rclk or negedge rd_reset_n) begin
        if (!rd_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            run_q   <= 1'b1;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pop) state_d = SHIFT;
            SHIFT:   if (acc && last && !pop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // Slice counter and word holding register
    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (flush) begin
            cnt_d = '0;
        end else if (pop) begin
            cnt_d  = '0;
            word_d = fifo_rd_data;
        end else if (acc) begin
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
    end

    // Outputs and pop strobe
    always_comb begin
        out_valid = (state_q == SHIFT);
        last      = (cnt_q == LAST_IDX);
        acc       = out_valid & out_ready;
        out_last  = out_valid & last;
        // Refill either from idle or on the accept of the final slice,
        // so consecutive words stream without a gap.
        pop = run_q & ~flush & ~fifo_empty
            & ((state_q == IDLE) | (acc & last));
        fifo_rd = pop;
        sel = LSB_FIRST ? cnt_q : (LAST_IDX - cnt_q);
        out_data = word_q[int'(sel)*OUT_WIDTH +: OUT_WIDTH];
    end

endmodule
